otp_auth_ctrl: RTL and testbench

Authentication controller directly downstream of the OTP display stage. It consumes the latched OTP and user-entry 7-segment patterns (`lfsr_out`, `user_out`) and the `otp_latch`/`user_latch` pulses that produce them. It compares the entry against the armed OTP and enforces an attempt limit, an OTP expiry window and a lockout period. It reports pass/fail/expiry events to the top level.

---
 rtl/otp_auth_pkg.sv | 21 ++
 rtl/otp_auth_timer.sv | 30 +++
 rtl/otp_auth_ctrl.sv | 139 +++++++++++++
 tb/tb_otp_auth_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/otp_auth_pkg.sv
// Shared types and helpers for the OTP authentication controller.
package otp_auth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAP_OTP,
    ST_ARMED,
    ST_CAP_USER,
    ST_LOCKED
  } otp_auth_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // One counter serves both windows, so size it for the longer one.
  function automatic int unsigned cnt_width(input int unsigned exp_c, input int unsigned lock_c);
    int unsigned m;
    m = (exp_c > lock_c) ? exp_c : lock_c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/otp_auth_timer.sv
// Up-counter with clear/enable; hit_o flags the cycle whose count equals term_i.
module otp_auth_timer
  import otp_auth_pkg::*;
#(
  parameter int unsigned W = 13
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] term_i,
  output logic         hit_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign hit_o = (cnt_q == term_i);

endmodule

// File: rtl/otp_auth_ctrl.sv
// OTP entry check with attempt limit, expiry window and lockout.
// Define OTP_AUTH_ASSERT_EN to compile in the internal SVA checks.
module otp_auth_ctrl
  import otp_auth_pkg::*;
#(
  parameter int unsigned MAX_ATTEMPTS   = 3,
  parameter int unsigned EXPIRY_CYCLES  = 5000,
  parameter int unsigned LOCKOUT_CYCLES = 1000
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              otp_latch,
  input  logic                              user_latch,
  input  logic [6:0]                        lfsr_out,
  input  logic [6:0]                        user_out,
  output logic                              armed,
  output logic                              auth_pass,
  output logic                              auth_fail,
  output logic                              expired,
  output logic                              locked,
  output logic [$clog2(MAX_ATTEMPTS+1)-1:0] attempts_left
);

  localparam int unsigned AW = $clog2(MAX_ATTEMPTS + 1);
  localparam int unsigned CW = cnt_width(EXPIRY_CYCLES, LOCKOUT_CYCLES);

  otp_auth_state_e state_q, state_d;
  logic          ph_q, ph_d;
  logic [6:0]    otp_q, otp_d, usr_q, usr_d;
  logic          armed_q, armed_d, pass_q, pass_d, fail_q, fail_d;
  logic          exp_q, exp_d, locked_q, locked_d;
  logic [AW-1:0] att_q, att_d;
  logic          tmr_clr, tmr_en, tmr_hit, match;
  logic [CW-1:0] tmr_term;

  // Capture states take two cycles: phase 0 samples the bus, phase 1 decides.
  assign ph_d  = (state_q == ST_CAP_OTP || state_q == ST_CAP_USER) && !ph_q;
  assign match = (usr_q == otp_q) && (usr_q != SEG_BLANK);

  always_comb begin
    otp_d = otp_q;
    usr_d = usr_q;
    if (state_q == ST_CAP_OTP  && !ph_q) otp_d = lfsr_out;
    if (state_q == ST_CAP_USER && !ph_q) usr_d = user_out;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (otp_latch) state_d = ST_CAP_OTP;
      ST_CAP_OTP:  if (ph_q) state_d = (otp_q == SEG_BLANK) ? ST_IDLE : ST_ARMED;
      ST_ARMED: begin
        if (otp_latch)       state_d = ST_CAP_OTP;
        else if (tmr_hit)    state_d = ST_IDLE;
        else if (user_latch) state_d = ST_CAP_USER;
      end
      ST_CAP_USER: if (ph_q) state_d = match ? ST_IDLE :
                                       (att_q == AW'(1)) ? ST_LOCKED : ST_ARMED;
      ST_LOCKED:   if (tmr_hit) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    armed_d  = (state_d == ST_ARMED) || (state_d == ST_CAP_USER);
    locked_d = (state_d == ST_LOCKED);
    pass_d   = (state_q == ST_CAP_USER) && ph_q && match;
    fail_d   = (state_q == ST_CAP_USER) && ph_q && !match;
    exp_d    = (state_q == ST_ARMED) && !otp_latch && tmr_hit;
    att_d    = att_q;
    if (state_q == ST_CAP_OTP && state_d == ST_ARMED) att_d = AW'(MAX_ATTEMPTS);
    else if (fail_d)                                   att_d = att_q - AW'(1);
    else if (!armed_d)                                 att_d = '0;
  end

  // Expiry and lockout never overlap, so one counter times both.
  assign tmr_clr  = (state_q == ST_CAP_OTP) || (state_d == ST_LOCKED && state_q != ST_LOCKED);
  assign tmr_en   = (state_q == ST_ARMED) || (state_q == ST_LOCKED);
  assign tmr_term = (state_q == ST_LOCKED) ? CW'(LOCKOUT_CYCLES - 1) : CW'(EXPIRY_CYCLES - 1);

  otp_auth_timer #(.W(CW)) u_timer (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .clr_i  (tmr_clr),
    .en_i   (tmr_en),
    .term_i (tmr_term),
    .hit_o  (tmr_hit)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      ph_q     <= 1'b0;
      otp_q    <= SEG_BLANK;
      usr_q    <= SEG_BLANK;
      armed_q  <= 1'b0;
      pass_q   <= 1'b0;
      fail_q   <= 1'b0;
      exp_q    <= 1'b0;
      locked_q <= 1'b0;
      att_q    <= '0;
    end else begin
      state_q  <= state_d;
      ph_q     <= ph_d;
      otp_q    <= otp_d;
      usr_q    <= usr_d;
      armed_q  <= armed_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      exp_q    <= exp_d;
      locked_q <= locked_d;
      att_q    <= att_d;
    end
  end

  assign armed         = armed_q;
  assign auth_pass     = pass_q;
  assign auth_fail     = fail_q;
  assign expired       = exp_q;
  assign locked        = locked_q;
  assign attempts_left = att_q;

`ifdef OTP_AUTH_ASSERT_EN
  a_known: assert property (@(posedge clk) disable iff (!reset_n)
    !$isunknown({armed, auth_pass, auth_fail, expired, locked, attempts_left}))
    else $error("otp_auth_ctrl: X on output at %0t", $time);
  a_excl: assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0({auth_pass, auth_fail, expired}))
    else $error("otp_auth_ctrl: overlapping event pulses at %0t", $time);
  a_lock_arm: assert property (@(posedge clk) disable iff (!reset_n) locked |-> !armed)
    else $error("otp_auth_ctrl: armed while locked at %0t", $time);
  a_att: assert property (@(posedge clk) disable iff (!reset_n) attempts_left <= MAX_ATTEMPTS)
    else $error("otp_auth_ctrl: attempts_left above limit at %0t", $time);
  a_lock_len: assert property (@(posedge clk) disable iff (!reset_n)
    $rose(locked) |-> locked [*LOCKOUT_CYCLES] ##1 !locked)
    else $error("otp_auth_ctrl: lockout length wrong at %0t", $time);
`endif

endmodule

// File: tb/tb_otp_auth_ctrl.sv
// Scoreboard bench: a transaction-level model predicts events, a monitor checks them.
module tb_otp_auth_ctrl;
  localparam int MAXA = 3, EXP = 16, LOCK = 1000;
  localparam int K_ARM = 0, K_ENT = 1, K_BOTH = 2;
  localparam int EV_PASS = 4, EV_FAIL = 2, EV_EXP = 1;

  logic clk = 1'b0, reset_n = 1'b0, otp_latch = 1'b0, user_latch = 1'b0;
  logic [6:0] lfsr_out = 7'h7F, user_out = 7'h7F;
  logic armed, auth_pass, auth_fail, expired, locked;
  logic [1:0] attempts_left;

  always #5 clk = ~clk;

  otp_auth_ctrl #(.MAX_ATTEMPTS(MAXA), .EXPIRY_CYCLES(EXP), .LOCKOUT_CYCLES(LOCK)) dut (
    .clk(clk), .reset_n(reset_n), .otp_latch(otp_latch), .user_latch(user_latch),
    .lfsr_out(lfsr_out), .user_out(user_out), .armed(armed), .auth_pass(auth_pass),
    .auth_fail(auth_fail), .expired(expired), .locked(locked), .attempts_left(attempts_left));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errs = 0, checks = 0;
  typedef struct { int ev; int at; int att; int arm; int lck; } exp_t;
  exp_t sbq[$];

  // Model state: what the spec says the block holds, in edge-index terms.
  bit         m_armed = 1'b0, m_lk = 1'b0;
  logic [6:0] m_otp = 7'h7F;
  int         m_att = 0, m_dl = 0, m_f = 0;
  logic [6:0] tbl [8] = '{7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h40, 7'h7F};

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errs++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  function automatic void push(input int ev, input int at, input int att, input int arm, input int lck);
    exp_t e;
    e.ev = ev; e.at = at; e.att = att; e.arm = arm; e.lck = lck;
    sbq.push_back(e);
  endfunction

  function automatic void expire(input int lim);
    if (m_armed && m_dl <= lim) begin
      m_armed = 1'b0; m_att = 0;
      push(EV_EXP, m_dl, 0, 0, 0);
    end
  endfunction

  function automatic bit lk_ign(input int m);
    return m_lk && m >= m_f + 1 && m <= m_f + LOCK;
  endfunction

  function automatic bit lk_at(input int c);
    return m_lk && c >= m_f && c <= m_f + LOCK - 1;
  endfunction

  task automatic step();
    @(posedge clk); #1;
    expire(cyc);
  endtask

  task automatic op(input int kind, input logic [6:0] vo, input logic [6:0] vu, input int gap);
    int m;
    m = cyc + 1;
    if (kind == K_ENT) begin
      expire(m);
      if (!lk_ign(m) && m_armed) begin
        if (vu == m_otp) begin
          m_armed = 1'b0; m_att = 0;
          push(EV_PASS, m + 2, 0, 0, 0);
        end else begin
          m_att--; m_dl += 2;
          if (m_att == 0) begin m_armed = 1'b0; m_lk = 1'b1; m_f = m + 2; end
          push(EV_FAIL, m + 2, m_att, int'(m_armed), int'(m_att == 0));
        end
      end
    end else if (!lk_ign(m)) begin
      if (vo == 7'h7F) begin m_armed = 1'b0; m_att = 0; end
      else begin m_armed = 1'b1; m_otp = vo; m_att = MAXA; m_dl = m + 2 + EXP; end
    end
    if (kind != K_ENT) begin otp_latch = 1'b1; lfsr_out = vo; end
    if (kind != K_ARM) begin user_latch = 1'b1; user_out = vu; end
    step();
    otp_latch = 1'b0; user_latch = 1'b0;
    repeat (gap) step();
    chk("armed", int'(armed), int'(m_armed));
    chk("attempts_left", int'(attempts_left), m_armed ? m_att : 0);
    chk("locked", int'(locked), int'(lk_at(cyc)));
  endtask

  task automatic check_reset_outs();
    chk("rst_armed", int'(armed), 0);
    chk("rst_pass", int'(auth_pass), 0);
    chk("rst_fail", int'(auth_fail), 0);
    chk("rst_expired", int'(expired), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_attempts", int'(attempts_left), 0);
  endtask

  // Monitor: every event pulse must match the head of the scoreboard.
  int lrun = 0;
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset_n) lrun = 0;
    else begin
      if (auth_pass || auth_fail || expired) begin
        if (sbq.size() == 0) begin
          checks++; errs++;
          $display("FAIL unexpected_event: got %b want none (cycle %0d)",
                   {auth_pass, auth_fail, expired}, cyc);
        end else begin
          e = sbq.pop_front();
          chk("event_kind", int'({auth_pass, auth_fail, expired}), e.ev);
          chk("event_cycle", cyc, e.at);
          chk("event_attempts", int'(attempts_left), e.att);
          chk("event_armed", int'(armed), e.arm);
          chk("event_locked", int'(locked), e.lck);
        end
      end
      if (locked) lrun++;
      else if (lrun > 0) begin chk("lock_len", lrun, LOCK); lrun = 0; end
    end
  end

  initial begin
    int kind, gap;
    logic [6:0] vo, vu;
    repeat (3) step();
    check_reset_outs();
    reset_n = 1'b1;
    step();

    op(K_ARM, 7'h79, 7'h7F, 3);
    op(K_ENT, 7'h7F, 7'h79, 3);
    op(K_ARM, 7'h79, 7'h7F, 2);
    repeat (3) op(K_ENT, 7'h7F, 7'h24, 3);
    op(K_ENT, 7'h7F, 7'h79, 5);
    while (lk_at(cyc)) step();
    step();
    op(K_ARM, 7'h30, 7'h7F, 25);
    op(K_ENT, 7'h7F, 7'h30, 4);
    op(K_ARM, 7'h79, 7'h7F, 2);
    op(K_ENT, 7'h7F, 7'h24, 3);
    op(K_BOTH, 7'h12, 7'h79, 3);
    op(K_ENT, 7'h7F, 7'h12, 3);
    op(K_ARM, 7'h7F, 7'h7F, 4);

    // Reset in the middle of a lockout.
    op(K_ARM, 7'h79, 7'h7F, 2);
    repeat (3) op(K_ENT, 7'h7F, 7'h24, 2);
    repeat (10) step();
    reset_n = 1'b0;
    #1;
    check_reset_outs();
    chk("pending_at_reset", sbq.size(), 0);
    m_armed = 1'b0; m_att = 0; m_lk = 1'b0;
    step(); step();
    reset_n = 1'b1;
    step();
    op(K_ARM, 7'h79, 7'h7F, 2);
    op(K_ENT, 7'h7F, 7'h79, 3);

    for (int i = 0; i < 150; i++) begin
      kind = int'($urandom_range(0, 9));
      kind = (kind < 3) ? K_ARM : (kind < 9) ? K_ENT : K_BOTH;
      vo = tbl[$urandom_range(0, 7)];
      vu = ($urandom_range(0, 2) != 0) ? m_otp : tbl[$urandom_range(0, 7)];
      gap = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(2, 6));
      op(kind, vo, vu, gap);
      if (lk_at(cyc)) begin
        op(K_ENT, 7'h7F, m_otp, 3);
        while (lk_at(cyc)) step();
        step();
      end
    end

    repeat (LOCK + EXP + 10) step();
    chk("scoreboard_drained", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
